// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MULU = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath: shift-add multiply (LSB-first) or restoring divide (MSB-first), one bit per step.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             load_i,
  input  logic             mode_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             last_o,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] quo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_q, a_q, b_q;
  logic [WIDTH-1:0] acc_d, a_d, b_d;
  logic [WIDTH-1:0] cur_acc, cur_a, cur_b;
  logic             cur_div, mode_q;
  logic [WIDTH:0]   shifted, diff;
  logic [CW-1:0]    cnt_q;

  // The load edge already performs the first bit, so WIDTH bits finish
  // after WIDTH-1 further steps.
  always_comb begin
    cur_acc = load_i ? '0 : acc_q;
    cur_a   = load_i ? X : a_q;
    cur_b   = load_i ? Y : b_q;
    cur_div = load_i ? mode_i : mode_q;
    shifted = {cur_acc, cur_a[WIDTH-1]};
    diff    = shifted - {1'b0, cur_b};
    if (cur_div) begin
      if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        a_d   = {cur_a[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shifted[WIDTH-1:0];
        a_d   = {cur_a[WIDTH-2:0], 1'b0};
      end
      b_d = cur_b;
    end else begin
      acc_d = cur_a[0] ? cur_acc + cur_b : cur_acc;
      a_d   = {1'b0, cur_a[WIDTH-1:1]};
      b_d   = {cur_b[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else if (load_i) begin
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      mode_q <= mode_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign last_o = (cnt_q == CW'(WIDTH - 2));
  assign acc_o  = acc_q;
  assign quo_o  = a_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic/slt plus iterative MULU/DIVU.
// Optional remainder output Rem is enabled with `define ALU_REM_EN.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             Start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [2:0]       Aluc,
  output logic [WIDTH-1:0] R,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             Dz,
  output logic             Busy,
  output logic             Done
`ifdef ALU_REM_EN
  ,
  output logic [WIDTH-1:0] Rem
`endif
);

  state_e           state_q;
  logic [2:0]       op_q;
  logic             dz_q;
  logic [WIDTH-1:0] r_q;
  logic             z_q, c_q, v_q, dzf_q, busy_q, done_q;
`ifdef ALU_REM_EN
  logic [WIDTH-1:0] rem_q, x_hold_q;
`endif

  logic             accept, multi, iter_last;
  logic [WIDTH-1:0] iter_acc, iter_quo, quick_r;
  logic             is_sub, ys_eff, ovf, lt, quick_c, quick_v;
  logic [WIDTH:0]   sum;

  // Handshake: a request is taken when Start=1 in IDLE and no Done is showing;
  // Busy covers the whole multi-cycle op, Done pulses once as R/flags update.
  // Blocking Start in the Done cycle keeps Done from ever pulsing twice in a row.
  assign accept = (state_q == S_IDLE) && Start && !done_q;
  assign multi  = (Aluc == OP_MULU) || (Aluc == OP_DIVU);

  always_comb begin
    is_sub  = (Aluc == OP_SUB) || (Aluc == OP_SLT);
    sum     = {1'b0, X} + {1'b0, (is_sub ? ~Y : Y)} + {{WIDTH{1'b0}}, is_sub};
    ys_eff  = is_sub ? ~Y[WIDTH-1] : Y[WIDTH-1];
    ovf     = (X[WIDTH-1] == ys_eff) && (sum[WIDTH-1] != X[WIDTH-1]);
    lt      = sum[WIDTH-1] ^ ovf;
    quick_r = '0;
    quick_c = 1'b0;
    quick_v = 1'b0;
    case (Aluc)
      OP_ADD, OP_SUB: begin
        quick_r = sum[WIDTH-1:0];
        quick_c = sum[WIDTH];
        quick_v = ovf;
      end
      OP_AND:  quick_r = X & Y;
      OP_OR:   quick_r = X | Y;
      OP_XOR:  quick_r = X ^ Y;
      OP_SLT:  quick_r = {{(WIDTH-1){1'b0}}, lt};
      default: quick_r = '0;
    endcase
  end

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .Clk    (Clk),
    .Clrn   (Clrn),
    .load_i (accept && multi),
    .mode_i (Aluc == OP_DIVU),
    .step_i (state_q == S_ITER),
    .X      (X),
    .Y      (Y),
    .last_o (iter_last),
    .acc_o  (iter_acc),
    .quo_o  (iter_quo)
  );

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      dz_q    <= 1'b0;
      r_q     <= '0;
      z_q     <= 1'b1;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      dzf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_REM_EN
      rem_q    <= '0;
      x_hold_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept && multi) begin
            op_q    <= Aluc;
            dz_q    <= (Aluc == OP_DIVU) && (Y == '0);
            busy_q  <= 1'b1;
            state_q <= ((Aluc == OP_DIVU) && (Y == '0)) ? S_FIN : S_ITER;
`ifdef ALU_REM_EN
            x_hold_q <= X;
`endif
          end else if (accept) begin
            r_q    <= quick_r;
            z_q    <= (quick_r == '0);
            c_q    <= quick_c;
            v_q    <= quick_v;
            dzf_q  <= 1'b0;
            done_q <= 1'b1;
`ifdef ALU_REM_EN
            rem_q <= '0;
`endif
          end
        end
        S_ITER: begin
          if (iter_last) state_q <= S_FIN;
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          c_q     <= 1'b0;
          v_q     <= 1'b0;
          dzf_q   <= dz_q;
          if (dz_q) begin
            r_q <= '1;
            z_q <= 1'b0;
          end else if (op_q == OP_DIVU) begin
            r_q <= iter_quo;
            z_q <= (iter_quo == '0);
          end else begin
            r_q <= iter_acc;
            z_q <= (iter_acc == '0);
          end
`ifdef ALU_REM_EN
          rem_q <= dz_q ? x_hold_q : ((op_q == OP_DIVU) ? iter_acc : '0);
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign R    = r_q;
  assign Z    = z_q;
  assign C    = c_q;
  assign V    = v_q;
  assign Dz   = dzf_q;
  assign Busy = busy_q;
  assign Done = done_q;
`ifdef ALU_REM_EN
  assign Rem  = rem_q;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vector table, multi-cycle corner sequences,
// randomized ops against an arithmetic reference model, and a WIDTH=8 instance.
module tb_alu_mc;

  localparam int W = 32;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SLT = 3'd5, MULU = 3'd6, DIVU = 3'd7;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  logic         start, z, c, v, dz, busy, done;
  logic [2:0]   aluc;
  logic [W-1:0] x, y, r;
  logic         start8, z8, c8, v8, dz8, busy8, done8;
  logic [2:0]   aluc8;
  logic [7:0]   x8, y8, r8;
`ifdef ALU_REM_EN
  logic [W-1:0] rem;
  logic [7:0]   rem8;
`endif

  alu_mc #(.WIDTH(W)) dut (
    .Clk(clk), .Clrn(clrn), .Start(start), .X(x), .Y(y), .Aluc(aluc),
    .R(r), .Z(z), .C(c), .V(v), .Dz(dz), .Busy(busy), .Done(done)
`ifdef ALU_REM_EN
    , .Rem(rem)
`endif
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .Clk(clk), .Clrn(clrn), .Start(start8), .X(x8), .Y(y8), .Aluc(aluc8),
    .R(r8), .Z(z8), .C(c8), .V(v8), .Dz(dz8), .Busy(busy8), .Done(done8)
`ifdef ALU_REM_EN
    , .Rem(rem8)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] r;
    logic         z, c, v, dz;
    logic [W-1:0] rem;
  } res_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, r;
    logic         z, c, v, dz;
    int           lat;
    logic [W-1:0] rem;
  } vec_t;

  logic [W-1:0] exp_q[$];
  logic [3:0]   flag_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t o;
    longint sa, sb, s, lim;
    logic [2*W-1:0] wide;
    o = '{default: '0};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    wide = '0;
    s = 0;
    case (op)
      ADD: begin
        o.r = a + b;
        wide = {{W{1'b0}}, a} + {{W{1'b0}}, b};
        o.c = wide[W];
        s = sa + sb;
        o.v = (s >= lim) || (s < -lim);
      end
      SUB: begin
        o.r = a - b;
        o.c = (a >= b);
        s = sa - sb;
        o.v = (s >= lim) || (s < -lim);
      end
      AND_: o.r = a & b;
      OR_:  o.r = a | b;
      XOR_: o.r = a ^ b;
      SLT:  o.r = (sa < sb) ? W'(1) : '0;
      MULU: begin
        wide = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        o.r = wide[W-1:0];
      end
      default: begin
        if (b == '0) begin
          o.r = '1; o.dz = 1'b1; o.rem = a;
        end else begin
          o.r = a / b; o.rem = a % b;
        end
      end
    endcase
    o.z = (o.r == '0);
    return o;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] b);
    if (op < MULU) return 1;
    if (op == DIVU && b == '0) return 2;
    return W + 1;
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_n);
    @(negedge clk);
    while (done) @(negedge clk);
    start = 1'b1; aluc = op; x = a; y = b;
    @(posedge clk); #1;
    start = 1'b0; x = $urandom; y = $urandom; aluc = 3'($urandom_range(0, 7));
    lat = 1; busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    while (done8) @(negedge clk);
    start8 = 1'b1; aluc8 = op; x8 = a; y8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; x8 = 8'($urandom);
    lat = 1;
    while (!done8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t tv[14];
  res_t m;
  int   lat, bn, n_done, first_done, dbl;
  logic prev_done;
  logic [W-1:0] r_at_done;
  logic [2:0]   op;
  logic [W-1:0] a, b;

  initial begin
    tv[0]  = '{ADD,  32'd7,          32'hFFFF_FFF9, 32'h0,          1, 1, 0, 0, 1,  32'h0};
    tv[1]  = '{SUB,  32'h8000_0000,  32'd1,         32'h7FFF_FFFF,  0, 1, 1, 0, 1,  32'h0};
    tv[2]  = '{SLT,  32'hFFFF_FFFF,  32'd1,         32'd1,          0, 0, 0, 0, 1,  32'h0};
    tv[3]  = '{MULU, 32'h0000_FFFF,  32'h0000_FFFF, 32'hFFFE_0001,  0, 0, 0, 0, 33, 32'h0};
    tv[4]  = '{DIVU, 32'd100,        32'd7,         32'd14,         0, 0, 0, 0, 33, 32'd2};
    tv[5]  = '{DIVU, 32'd5,          32'd0,         32'hFFFF_FFFF,  0, 0, 0, 1, 2,  32'd5};
    tv[6]  = '{AND_, 32'hF0F0_F0F0,  32'hFF00_FF00, 32'hF000_F000,  0, 0, 0, 0, 1,  32'h0};
    tv[7]  = '{OR_,  32'h0,          32'h0,         32'h0,          1, 0, 0, 0, 1,  32'h0};
    tv[8]  = '{XOR_, 32'hA5A5_A5A5,  32'hFFFF_FFFF, 32'h5A5A_5A5A,  0, 0, 0, 0, 1,  32'h0};
    tv[9]  = '{ADD,  32'h7FFF_FFFF,  32'd1,         32'h8000_0000,  0, 0, 1, 0, 1,  32'h0};
    tv[10] = '{SLT,  32'd1,          32'hFFFF_FFFF, 32'h0,          1, 0, 0, 0, 1,  32'h0};
    tv[11] = '{SUB,  32'd5,          32'd5,         32'h0,          1, 1, 0, 0, 1,  32'h0};
    tv[12] = '{DIVU, 32'd7,          32'd100,       32'h0,          1, 0, 0, 0, 33, 32'd7};
    tv[13] = '{MULU, 32'h8000_0001,  32'd3,         32'h8000_0003,  0, 0, 0, 0, 33, 32'h0};

    start = 0; aluc = '0; x = '0; y = '0;
    start8 = 0; aluc8 = '0; x8 = '0; y8 = '0;
    clrn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.R", 64'(r), 64'h0);
    check("reset.ZCVDz", {60'h0, z, c, v, dz}, {60'h0, 4'b1000});
    check("reset.BusyDone", {62'h0, busy, done}, 64'h0);
    @(negedge clk);
    clrn = 1'b1;

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      do_op(tv[i].op, tv[i].a, tv[i].b, lat, bn);
      check($sformatf("vec%0d.latency", i), 64'(lat), 64'(tv[i].lat));
      check($sformatf("vec%0d.busy_cycles", i), 64'(bn), 64'(tv[i].lat - 1));
      check($sformatf("vec%0d.R", i), 64'(r), 64'(tv[i].r));
      check($sformatf("vec%0d.ZCVDz", i), {60'h0, z, c, v, dz}, {60'h0, tv[i].z, tv[i].c, tv[i].v, tv[i].dz});
`ifdef ALU_REM_EN
      check($sformatf("vec%0d.Rem", i), 64'(rem), 64'(tv[i].rem));
`endif
      @(posedge clk); #1;
      check($sformatf("vec%0d.done_one_cycle", i), {63'h0, done}, 64'h0);
      check($sformatf("vec%0d.R_hold", i), 64'(r), 64'(tv[i].r));
    end

    // Start pulses during ITER and in the FIN cycle must be ignored.
    @(negedge clk);
    while (done) @(negedge clk);
    start = 1'b1; aluc = MULU; x = 32'hFFFF; y = 32'hFFFF;
    @(negedge clk);
    n_done = 0; first_done = 0; dbl = 0; prev_done = 1'b0; r_at_done = '0;
    for (int k = 1; k <= 45; k++) begin
      start = (k == 5) || (k == W);
      aluc = ADD; x = 32'd1; y = 32'd2;
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (first_done == 0) begin first_done = k + 1; r_at_done = r; end
      end
      if (done && prev_done) dbl++;
      prev_done = done;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_start.done_count", 64'(n_done), 64'd1);
    check("busy_start.done_cycle", 64'(first_done), 64'(W + 1));
    check("busy_start.R", 64'(r_at_done), 64'hFFFE_0001);
    check("busy_start.no_double_done", 64'(dbl), 64'd0);

    // Mid-operation reset aborts without a Done.
    do_op(DIVU, 32'd9, 32'd0, lat, bn);
    check("pre_reset.Dz", {63'h0, dz}, 64'h1);
    @(negedge clk);
    start = 1'b1; aluc = DIVU; x = 32'd1000; y = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 clrn = 1'b0;
    #1;
    check("midreset.R", 64'(r), 64'h0);
    check("midreset.ZCVDz", {60'h0, z, c, v, dz}, {60'h0, 4'b1000});
    check("midreset.BusyDone", {62'h0, busy, done}, 64'h0);
    @(negedge clk);
    clrn = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("midreset.no_done_after", 64'(n_done), 64'd0);
    check("midreset.R_after", 64'(r), 64'h0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = W'($urandom_range(0, 15));
        2: a = W'($urandom_range(0, 255));
        3: begin a = {1'b1, 31'($urandom)}; b = {1'b0, 31'($urandom)}; end
        default: ;
      endcase
      m = model(op, a, b);
      exp_q.push_back(m.r);
      flag_q.push_back({m.z, m.c, m.v, m.dz});
      do_op(op, a, b, lat, bn);
      check($sformatf("rnd%0d.op%0d.latency", i, op), 64'(lat), 64'(exp_lat(op, b)));
      check($sformatf("rnd%0d.op%0d.R", i, op), 64'(r), 64'(exp_q.pop_front()));
      check($sformatf("rnd%0d.op%0d.ZCVDz", i, op), {60'h0, z, c, v, dz}, {60'h0, flag_q.pop_front()});
`ifdef ALU_REM_EN
      check($sformatf("rnd%0d.op%0d.Rem", i, op), 64'(rem), 64'(m.rem));
`endif
    end

    // Narrow instance.
    do_op8(MULU, 8'h0F, 8'h11, lat);
    check("w8.mulu.latency", 64'(lat), 64'd9);
    check("w8.mulu.R", 64'(r8), 64'hFF);
    check("w8.mulu.ZCVDz", {60'h0, z8, c8, v8, dz8}, 64'h0);
    do_op8(DIVU, 8'd200, 8'd13, lat);
    check("w8.divu.latency", 64'(lat), 64'd9);
    check("w8.divu.R", 64'(r8), 64'd15);
`ifdef ALU_REM_EN
    check("w8.divu.Rem", 64'(rem8), 64'd5);
`endif
    do_op8(DIVU, 8'd77, 8'd0, lat);
    check("w8.divz.latency", 64'(lat), 64'd2);
    check("w8.divz.R", 64'(r8), 64'hFF);
    check("w8.divz.ZDz", {62'h0, z8, dz8}, 64'h1);
    do_op8(ADD, 8'h7F, 8'h81, lat);
    check("w8.add.latency", 64'(lat), 64'd1);
    check("w8.add.R", 64'(r8), 64'h00);
    check("w8.add.ZCVDz", {60'h0, z8, c8, v8, dz8}, {60'h0, 4'b1100});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
